seq_detector_param: RTL and testbench

Parametrised serial sequence detector: the generalised successor to the team's fixed 4-bit Mealy detectors. It samples one serial bit per qualified clock, matches against a compile-time pattern of configurable length, and supports overlapping or non-overlapping match modes. It sits between a serial input stage and the control logic, which consumes a one-cycle registered match pulse and an optional match counter.

---
 rtl/seq_detector_param.sv | 76 +++++++
 tb/tb_seq_detector_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised KMP serial sequence detector; define SEQ_DET_COUNT_EN to build the saturating match counter
module seq_detector_param #(
   parameter int LEN = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1100,
   parameter int OVERLAP = 1,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   input  logic in_valid,
   input  logic clear,
   output logic z,
   output logic [CNT_W-1:0] match_count
);
   localparam int PW = $clog2(LEN);
   localparam int NS = 1 << PW;

   function automatic logic pat_bit(input int i);
      logic [LEN-1:0] t;
      t = PATTERN >> i;
      return t[0];
   endfunction

   // longest prefix (capped at LEN-1) that is a suffix of prefix_p followed by b;
   // at prog=LEN-1 with a completing bit this yields the pattern's proper border
   function automatic int step(input int p, input logic b);
      int r = 0;
      int idx;
      logic ok;
      for (int k = 1; k <= p + 1 && k < LEN; k++) begin
         ok = 1'b1;
         for (int j = 0; j < k; j++) begin
            idx = p + 1 - k + j;
            if ((idx < p ? pat_bit(LEN - 1 - idx) : b) != pat_bit(LEN - 1 - j)) ok = 1'b0;
         end
         if (ok) r = k;
      end
      return r;
   endfunction

   logic [PW-1:0] prog, prog_nxt;
   logic [PW-1:0] nxt0 [NS];
   logic [PW-1:0] nxt1 [NS];
   logic match;

   for (genvar i = 0; i < NS; i++) begin : g_tab
      assign nxt0[i] = (i < LEN) ? PW'(step(i, 1'b0)) : '0;
      assign nxt1[i] = (i < LEN) ? PW'(step(i, 1'b1)) : '0;
   end

   // match detect and next progress; clear beats in_valid, idle cycles hold
   always_comb begin
      match = in_valid && !clear && prog == PW'(LEN - 1) && in == PATTERN[0];
      prog_nxt = clear ? '0 : !in_valid ? prog : (match && OVERLAP == 0) ? '0 : in ? nxt1[prog] : nxt0[prog];
   end

   // progress register and registered match pulse
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         prog <= '0;
         z <= 1'b0;
      end else begin
         prog <= prog_nxt;
         z <= match;
      end

`ifdef SEQ_DET_COUNT_EN
   // saturating match counter, unaffected by clear
   always_ff @(posedge clk or posedge reset)
      if (reset) match_count <= '0;
      else if (match && match_count != {CNT_W{1'b1}}) match_count <= match_count + 1'b1;
`else
   assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of several detector configurations
module tb_seq_detector_param;
   logic clk = 1'b0, reset = 1'b0, in = 1'b0, in_valid = 1'b0, clear = 1'b0;
   logic z0, z1, z2, z3, z4;
   logic [7:0] c0, c1, c2, c4;
   logic [1:0] c3;
   int checks = 0, errors = 0;
`ifdef SEQ_DET_COUNT_EN
   localparam int CE = 1;
`else
   localparam int CE = 0;
`endif
   bit s2 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   bit e1 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   bit e2 [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   bit e4 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   int sat [5] = '{1, 2, 3, 3, 3};

   always #5 clk = ~clk;

   seq_detector_param u0 (.clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear), .z(z0), .match_count(c0));
   seq_detector_param #(.PATTERN(4'b1010), .OVERLAP(1)) u1 (.clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear), .z(z1), .match_count(c1));
   seq_detector_param #(.PATTERN(4'b1010), .OVERLAP(0)) u2 (.clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear), .z(z2), .match_count(c2));
   seq_detector_param #(.CNT_W(2)) u3 (.clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear), .z(z3), .match_count(c3));
   seq_detector_param #(.LEN(3), .PATTERN(3'b111), .OVERLAP(1)) u4 (.clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .clear(clear), .z(z4), .match_count(c4));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic b);
      in = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input logic b);
      in = b;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      clear = 1'b0;
      in = 1'b0;
      #2;
      reset = 1'b0;
      #1;
   endtask

   task automatic seq1100();
      send(1'b1);
      send(1'b1);
      send(1'b0);
      send(1'b0);
   endtask

   initial begin
      do_reset();
      chk("rst_z", 32'(z0), 0);
      chk("rst_cnt", 32'(c0), 0);
      // basic 1100
      send(1'b1);
      send(1'b1);
      send(1'b0);
      chk("t1_pre", 32'(z0), 0);
      send(1'b0);
      chk("t1_z", 32'(z0), 1);
      chk("t1_cnt", 32'(c0), CE);
      send(1'b0);
      chk("t1_fall", 32'(z0), 0);
      chk("t1_cnt_hold", 32'(c0), CE);
      seq1100();
      chk("t1_z2", 32'(z0), 1);
      chk("t1_cnt2", 32'(c0), 2 * CE);
      // async reset while z is high
      reset = 1'b1;
      #1;
      chk("rst_async_z", 32'(z0), 0);
      chk("rst_async_cnt", 32'(c0), 0);
      reset = 1'b0;
      #1;
      // 1010 overlapping vs non-overlapping
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send(s2[i]);
         chk("t2_ov", 32'(z1), 32'(e1[i]));
         chk("t2_nov", 32'(z2), 32'(e2[i]));
      end
      chk("t2_ov_cnt", 32'(c1), 2 * CE);
      chk("t2_nov_cnt", 32'(c2), CE);
      // idle cycles ignored
      do_reset();
      send(1'b1);
      send(1'b1);
      gap(1'b0);
      chk("t3_gap0", 32'(z0), 0);
      gap(1'b0);
      chk("t3_gap1", 32'(z0), 0);
      gap(1'b1);
      chk("t3_gap2", 32'(z0), 0);
      send(1'b0);
      chk("t3_pre", 32'(z0), 0);
      send(1'b0);
      chk("t3_z", 32'(z0), 1);
      chk("t3_cnt", 32'(c0), CE);
      // failure transition keeps partial progress
      do_reset();
      send(1'b1);
      send(1'b1);
      send(1'b1);
      chk("t4_111", 32'(z0), 0);
      send(1'b0);
      chk("t4_1110", 32'(z0), 0);
      send(1'b0);
      chk("t4_z", 32'(z0), 1);
      // reset mid-sequence discards progress
      do_reset();
      send(1'b1);
      send(1'b1);
      send(1'b0);
      do_reset();
      send(1'b0);
      chk("t5_after_rst", 32'(z0), 0);
      chk("t5_cnt0", 32'(c0), 0);
      send(1'b1);
      send(1'b1);
      send(1'b0);
      chk("t5_pre", 32'(z0), 0);
      send(1'b0);
      chk("t5_z", 32'(z0), 1);
      // clear restarts history but keeps the count
      do_reset();
      seq1100();
      chk("t6_z", 32'(z0), 1);
      send(1'b1);
      send(1'b1);
      clear = 1'b1;
      send(1'b0);
      chk("t6_clr_z", 32'(z0), 0);
      clear = 1'b0;
      send(1'b0);
      chk("t6_no_match", 32'(z0), 0);
      chk("t6_cnt_kept", 32'(c0), CE);
      seq1100();
      chk("t6_z2", 32'(z0), 1);
      chk("t6_cnt2", 32'(c0), 2 * CE);
      // 2-bit counter saturation
      do_reset();
      for (int m = 0; m < 5; m++) begin
         seq1100();
         chk("t7_z", 32'(z3), 1);
         chk("t7_cnt", 32'(c3), 32'(sat[m] * CE));
      end
      // back-to-back pulses, non-power-of-two length
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         chk("t8_z", 32'(z4), 32'(e4[i]));
      end
      send(1'b0);
      chk("t8_fall", 32'(z4), 0);
      chk("t8_cnt", 32'(c4), 3 * CE);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
